alu_dispatch: RTL

- Issue-side counterpart of the SCM16 ALU: accepts decoded ALU commands, reads operands from an internal 8x16 register file and drives the ALU's Instruction/Input_1/Input_2/Enable pins.
- Waits a fixed latency, captures the ALU Output, writes it back and reports completion.
- Sits between the SCM16 control unit and the ALU; one command in flight at a time.

---
 rtl/alu_dispatch.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Issue-side dispatcher for the SCM16 ALU: reads operands from an 8x16 register
// file, drives the ALU for ALU_WAIT cycles, then writes the result back and reports.
module alu_dispatch #(
  parameter int unsigned ALU_WAIT = 1,
  parameter int unsigned NREGS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_instr,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] alu_instruction,
  output logic [15:0] alu_input_1,
  output logic [15:0] alu_input_2,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT - 1);

  state_t      state_q, state_d;
  logic [12:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];

  logic [3:0] opcode;
  logic [2:0] dst, src_a, src_b;
  logic       issuing;
  logic       unused_instr_bits;

  assign opcode = instr_q[3:0];
  assign dst    = instr_q[6:4];
  assign src_a  = instr_q[9:7];
  assign src_b  = instr_q[12:10];
  assign unused_instr_bits = ^cmd_instr[15:13];

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    err_d    = err_q;
    result_d = result_q;
    wait_d   = wait_q;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        // Load lands at the handshake edge, so a same-cycle command reads the new value
        if (ld_en) regs_d[ld_addr] = ld_data;
        if (cmd_valid) begin
          instr_d  = cmd_instr[12:0];
          err_d    = (cmd_instr[3:0] > 4'd11);
          result_d = '0;
          wait_d   = '0;
          state_d  = (cmd_instr[3:0] > 4'd11) ? WB : ISSUE;
        end
      end
      ISSUE: begin
        if (wait_q == WAIT_LAST) begin
          result_d = alu_result;
          wait_d   = '0;
          state_d  = WB;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      WB: begin
        if (!err_q) regs_d[dst] = result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      wait_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
      result_q <= result_d;
      wait_q   <= wait_d;
      regs_q   <= regs_d;
    end
  end

  assign issuing         = (state_q == ISSUE);
  assign cmd_ready       = (state_q == IDLE);
  assign alu_enable      = issuing;
  assign alu_instruction = issuing ? {12'd0, opcode} : '0;
  assign alu_input_1     = issuing ? regs_q[src_a] : '0;
  assign alu_input_2     = issuing ? regs_q[src_b] : '0;
  assign rsp_valid       = (state_q == WB);
  assign rsp_err         = rsp_valid & err_q;
  assign rsp_data        = (rsp_valid && !err_q) ? result_q : '0;

endmodule
